// File: rtl/benes_xbar_pipe.sv
// Pipelined Benes permutation network: one registered switch layer per stage, valid/ready flow control.
// Optional XBAR_PERF_CNT_EN adds a 32-bit delivered-beat counter on port beat_cnt.
module benes_xbar_pipe #(
  parameter  int unsigned SIZE     = 32,
  parameter  int unsigned DW       = 16,
  localparam int unsigned TAGWIDTH = $clog2(SIZE),
  localparam int unsigned STAGES   = 2 * TAGWIDTH - 1,
  localparam int unsigned CBITS    = STAGES * SIZE / 2
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 ctrl_valid,
  output logic                 ctrl_ready,
  input  logic [CBITS-1:0]     ctrl,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SIZE*DW-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIZE*DW-1:0]   out_data
`ifdef XBAR_PERF_CNT_EN
  ,
  output logic [31:0]          beat_cnt
`endif
);

  localparam int unsigned HALF = SIZE / 2;

  logic [CBITS-1:0]   ctrl_q;
  logic [STAGES-1:0]  v_q;
  logic [STAGES-1:0]  v_up;
  logic [STAGES-1:0]  rdy;
  logic [SIZE*DW-1:0] data_q    [STAGES];
  logic [SIZE*DW-1:0] layer_out [STAGES];
  logic               ctrl_load;
  logic               accept;

  // Control word may only change while nothing is in flight.
  assign ctrl_ready = ~|v_q;
  assign ctrl_load  = ctrl_valid && ctrl_ready;
  assign in_ready   = rdy[0] && !ctrl_load;
  assign accept     = in_valid && in_ready;
  assign v_up       = {v_q[STAGES-2:0], accept};

  // A stage can take data if it or any stage downstream holds a bubble, or the sink is ready.
  for (genvar s = 0; s < STAGES; s++) begin : g_rdy
    assign rdy[s] = out_ready || !(&v_q[STAGES-1:s]);
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_layer
    localparam int unsigned GAP = 1 << ((s < STAGES - 1 - s) ? s : STAGES - 1 - s);
    logic [SIZE*DW-1:0] lin;
    logic [SIZE*DW-1:0] lout;

    if (s == 0) begin : g_src_in
      assign lin = in_data;
    end else begin : g_src_reg
      assign lin = data_q[s-1];
    end

    for (genvar j = 0; j < HALF; j++) begin : g_sw
      localparam int unsigned POS = (j % GAP) + 2 * GAP * (j / GAP);
      localparam int unsigned CB  = s * HALF + j;
      assign lout[POS*DW +: DW]       = ctrl_q[CB] ? lin[(POS+GAP)*DW +: DW] : lin[POS*DW +: DW];
      assign lout[(POS+GAP)*DW +: DW] = ctrl_q[CB] ? lin[POS*DW +: DW]       : lin[(POS+GAP)*DW +: DW];
    end

    assign layer_out[s] = lout;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ctrl_q <= '0;
    end else if (ctrl_load) begin
      ctrl_q <= ctrl;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v_q <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (rdy[s]) v_q[s] <= v_up[s];
      end
    end
  end

  // Data registers carry no reset; they only load when a valid beat moves in.
  always_ff @(posedge clk) begin
    for (int s = 0; s < STAGES; s++) begin
      if (rdy[s] && v_up[s]) data_q[s] <= layer_out[s];
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];

`ifdef XBAR_PERF_CNT_EN
  logic [31:0] beat_cnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      beat_cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
    end
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_benes_xbar_pipe.sv
// Directed bench for benes_xbar_pipe: permutation-level scoreboard plus literal lane checks.
// Exercises the XBAR_PERF_CNT_EN counter when that macro is defined.
module tb_benes_xbar_pipe;

  localparam int unsigned SIZE   = 32;
  localparam int unsigned DW     = 16;
  localparam int unsigned STAGES = 9;
  localparam int unsigned HALF   = SIZE / 2;
  localparam int unsigned CBITS  = STAGES * HALF;

  typedef logic [SIZE*DW-1:0] beat_t;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             ctrl_valid;
  logic             ctrl_ready;
  logic [CBITS-1:0] ctrl;
  logic             in_valid;
  logic             in_ready;
  beat_t            in_data;
  logic             out_valid;
  logic             out_ready;
  beat_t            out_data;
`ifdef XBAR_PERF_CNT_EN
  logic [31:0]      beat_cnt;
`endif

  benes_xbar_pipe #(.SIZE(SIZE), .DW(DW)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .ctrl       (ctrl),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef XBAR_PERF_CNT_EN
    ,
    .beat_cnt   (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model: out lane k = in lane pi[k]; pi is set by the test alongside each ctrl load.
  int unsigned pi [SIZE];
  beat_t       exp_q[$];
  int          vectors   = 0;
  int          errors    = 0;
  int          delivered = 0;
  logic        stall_prev = 1'b0;
  beat_t       hold_data;

  function automatic beat_t permute(input beat_t b);
    beat_t r;
    for (int k = 0; k < SIZE; k++) r[k*DW +: DW] = b[pi[k]*DW +: DW];
    return r;
  endfunction

  function automatic logic [DW-1:0] lane(input beat_t b, input int k);
    return b[k*DW +: DW];
  endfunction

  function automatic beat_t make_beat(input int unsigned base);
    beat_t r;
    for (int i = 0; i < SIZE; i++) r[i*DW +: DW] = DW'(base + i);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!n_rst) begin
      stall_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) exp_q.push_back(permute(in_data));
      if (stall_prev) begin
        vectors++;
        if (!out_valid || out_data !== hold_data) begin
          errors++;
          $display("FAIL stall_hold: out_valid=%0b data changed=%0b, required valid=1 unchanged",
                   out_valid, out_data !== hold_data);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        delivered++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stray_beat: got %h, required no beat", out_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL beat_data: got %h, required %h", out_data, e);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      hold_data  = out_data;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pi_xor(input int unsigned m);
    for (int k = 0; k < SIZE; k++) pi[k] = int'(unsigned'(k) ^ m);
  endtask

  task automatic load_ctrl(input logic [CBITS-1:0] c);
    int n;
    n = 0;
    ctrl = c;
    ctrl_valid = 1'b1;
    #1;
    while (!ctrl_ready && n < 100) begin
      tick();
      n++;
    end
    check("ctrl_ready_load", 32'(ctrl_ready), 32'd1);
    check("in_ready_during_load", 32'(in_ready), 32'd0);
    tick();
    ctrl_valid = 1'b0;
  endtask

  task automatic send_beat(input beat_t b);
    int n;
    n = 0;
    in_data = b;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      vectors++;
      errors++;
      $display("FAIL out_timeout: out_valid=0 after %0d cycles, required 1", lat);
    end
  endtask

  // Layers whose every switch crosses turn position p into p^gap; gaps 1,4,16 on layers 8,6,4.
  function automatic logic [CBITS-1:0] layers_all(input logic [STAGES-1:0] sel);
    logic [CBITS-1:0] c;
    c = '0;
    for (int s = 0; s < STAGES; s++)
      if (sel[s]) for (int j = 0; j < HALF; j++) c[s*HALF + j] = 1'b1;
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int d0;
    int seen_full;
    int sent;
    logic [CBITS-1:0] c;
    logic [CBITS-1:0] c_rev;
    beat_t b;

    n_rst = 1'b0; ctrl_valid = 1'b0; ctrl = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    set_pi_xor(0);
    #23;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    #1;
    check("reset_ctrl_ready", 32'(ctrl_ready), 32'd1);
    check("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef XBAR_PERF_CNT_EN
    check("reset_beat_cnt", beat_cnt, 32'd0);
`endif
    tick();

    // Identity after reset, with latency measurement.
    send_beat(make_beat(0));
    wait_out(lat);
    check("latency_identity", 32'(lat + 1), 32'd9);
    check("identity_lane5", 32'(lane(out_data, 5)), 32'h0005);
    check("identity_lane31", 32'(lane(out_data, 31)), 32'h001F);
    tick();

    // Reversal: crossing every switch of the gap-16/8/4/2/1 layers (4..8) maps k -> k^31 = 31-k.
    c_rev = layers_all(9'b1_1111_0000);
    load_ctrl(c_rev);
    for (int k = 0; k < SIZE; k++) pi[k] = 31 - k;
    send_beat(make_beat(32'h100));
    wait_out(lat);
    check("latency_reverse", 32'(lat + 1), 32'd9);
    check("reverse_lane0", 32'(lane(out_data, 0)), 32'h011F);
    check("reverse_lane10", 32'(lane(out_data, 10)), 32'h0115);
    check("reverse_lane31", 32'(lane(out_data, 31)), 32'h0100);
    tick();

    // Single switches: L0 sw0 (0,1), L2 sw5 gap4 (9,13), L4 sw5 gap16 (5,21), L8 sw3 gap1 (6,7).
    c = '0;
    c[0] = 1'b1; c[37] = 1'b1; c[69] = 1'b1; c[131] = 1'b1;
    load_ctrl(c);
    set_pi_xor(0);
    pi[0] = 1; pi[1] = 0; pi[9] = 13; pi[13] = 9; pi[5] = 21; pi[21] = 5; pi[6] = 7; pi[7] = 6;
    send_beat(make_beat(32'h200));
    wait_out(lat);
    check("sparse_lane0", 32'(lane(out_data, 0)), 32'h0201);
    check("sparse_lane1", 32'(lane(out_data, 1)), 32'h0200);
    check("sparse_lane2", 32'(lane(out_data, 2)), 32'h0202);
    check("sparse_lane9", 32'(lane(out_data, 9)), 32'h020D);
    check("sparse_lane21", 32'(lane(out_data, 21)), 32'h0205);
    check("sparse_lane7", 32'(lane(out_data, 7)), 32'h0206);
    tick();

    // Stream of 20 beats with sink stalled in cycles 12..15; permutation k -> k^21.
    load_ctrl(layers_all(9'b1_0101_0000));
    set_pi_xor(21);
    d0 = delivered;
    sent = 0;
    seen_full = 0;
    for (int cyc = 0; cyc < 80 && !(sent == 20 && delivered - d0 == 20); cyc++) begin
      out_ready = !(cyc >= 12 && cyc <= 15);
      in_valid  = (sent < 20);
      in_data   = make_beat(32'h1000 + 32'(sent) * 32);
      #1;
      if (cyc == 11) check("stream_in_ready_c11", 32'(in_ready), 32'd1);
      if (cyc == 12) check("stream_in_ready_c12", 32'(in_ready), 32'd0);
      if (in_valid && !in_ready) seen_full = 1;
      lat = int'(in_valid && in_ready);
      @(posedge clk); #1;
      sent += lat;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_in_ready_dropped", 32'(seen_full), 32'd1);
    check("stream_delivered", 32'(delivered - d0), 32'd20);
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    // Control load requested while three beats are in flight.
    d0 = delivered;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = make_beat(32'h2000 + 32'(i) * 32);
      tick();
    end
    in_valid = 1'b0;
    ctrl = c_rev;
    ctrl_valid = 1'b1;
    #1;
    check("ctrl_ready_busy", 32'(ctrl_ready), 32'd0);
    lat = 0;
    while (!ctrl_ready && lat < 50) begin
      tick();
      lat++;
    end
    check("ctrl_ready_drained", 32'(ctrl_ready), 32'd1);
    check("in_ready_load_cycle", 32'(in_ready), 32'd0);
    check("drained_before_load", 32'(delivered - d0), 32'd3);
    tick();
    ctrl_valid = 1'b0;
    for (int k = 0; k < SIZE; k++) pi[k] = 31 - k;
    send_beat(make_beat(32'h500));
    wait_out(lat);
    check("after_load_lane0", 32'(lane(out_data, 0)), 32'h051F);
    tick();

    // Reset with five beats stalled in the pipe; ctrl_q must return to identity.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = make_beat(32'h3000 + 32'(i) * 32);
      tick();
    end
    in_valid = 1'b0;
    wait_out(lat);
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    check("reset_mid_out_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    n_rst = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_reset_ctrl_ready", 32'(ctrl_ready), 32'd1);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    d0 = delivered;
    for (int i = 0; i < 15; i++) tick();
    check("no_stale_beats", 32'(delivered - d0), 32'd0);
    set_pi_xor(0);
    send_beat(make_beat(32'h300));
    wait_out(lat);
    check("post_reset_identity_lane3", 32'(lane(out_data, 3)), 32'h0303);
    tick();

`ifdef XBAR_PERF_CNT_EN
    @(negedge clk);
    force dut.beat_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.beat_cnt_q;
    #1;
    check("beat_cnt_preload", beat_cnt, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    send_beat(make_beat(32'h400));
    wait_out(lat);
    tick();
    check("beat_cnt_wrap", beat_cnt, 32'd0);
`endif

    for (int i = 0; i < 5; i++) tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/benes_xbar_pipe.md
BENES_XBAR_PIPE -- requirements
Module: benes_xbar_pipe

Interface
REQ-001 SHALL have parameter SIZE, default 32, the number of lanes (power of two, at least 4).
REQ-002 SHALL have parameter DW, default 16, the data bits per lane.
REQ-003 SHALL have derived localparams TAGWIDTH=$clog2(SIZE), STAGES=2*TAGWIDTH-1 and CBITS=STAGES*SIZE/2 (144 at default).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-005 SHALL have port n_rst, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have ports ctrl_valid (input, 1), ctrl_ready (output, 1) and ctrl (input, CBITS): control-word load handshake; ctrl is the output of the control-bit generator.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, SIZE*DW): input beat; lane i is in_data[i*DW +: DW].
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, SIZE*DW): the permuted beat.
REQ-009 SHALL have port beat_cnt, output, 32 bits, only when XBAR_PERF_CNT_EN is defined.

Function
REQ-010 SHALL hold a CBITS-bit register ctrl_q; a ctrl load occurs when ctrl_valid && ctrl_ready, and ctrl_q = ctrl at the next edge.
REQ-011 SHALL drive ctrl_ready = 1 only when every pipeline stage valid bit is 0 (pipeline empty).
REQ-012 SHALL drive in_ready = ready_0 && !(ctrl_valid && ctrl_ready); a ctrl load has priority, and no beat is accepted in the cycle a ctrl load occurs.
REQ-013 SHALL have STAGES network layers; layer s uses gap = 1 << min(s, STAGES-1-s).
REQ-014 SHALL have layer s contain SIZE/2 switches; switch j pairs positions pos = (j % gap) + 2*gap*(j / gap) and pos+gap.
REQ-015 SHALL swap the pair of switch j in layer s when ctrl_q[s*SIZE/2 + j] = 1, and pass it straight when the bit is 0.
REQ-016 SHALL have each layer feed a pipeline register with a valid bit v_s; out_data/out_valid are register STAGES-1.
REQ-017 SHALL define per-stage ready as ready_s = !v_s || ready_(s+1), with ready_STAGES = out_ready, so bubbles collapse.
REQ-018 SHALL give a latency of exactly STAGES cycles (9 at default) from in_valid && in_ready to out_valid when unstalled; throughput is 1 beat per cycle.
REQ-019 SHALL hold out_data and out_valid stable while out_valid && !out_ready; no beat is dropped or duplicated.
REQ-020 SHALL mean, for a given ctrl, that out lane k carries in lane pi[k], where pi is the permutation the generator was given.
REQ-021 SHALL pass data straight through when ctrl_q = 0 (identity).
REQ-022 SHALL not gate data registers by reset; only valid bits and ctrl_q are reset.

Reset
REQ-023 SHALL, on n_rst low, immediately clear all v_s to 0 (out_valid = 0) and ctrl_q to 0, and clear beat_cnt to 0 when present.
REQ-024 SHALL discard in-flight beats on reset mid-operation; after release, ctrl_ready = 1 and in_ready = 1.

Configuration
REQ-025 SHALL, with XBAR_PERF_CNT_EN defined, provide a 32-bit beat_cnt that increments on each out_valid && out_ready and wraps 0xFFFFFFFF -> 0.
REQ-026 SHALL, without XBAR_PERF_CNT_EN, have no beat_cnt port and no counter flops; behaviour is otherwise identical.

Verification
REQ-027 SHALL cover: reset, then a beat with lane i = i and ctrl_q = 0 -> after 9 cycles out lane i = i.
REQ-028 SHALL cover: ctrl from the generator for reversal pi[k] = 31-k, then beat lane i = 0x100+i -> out lane k = 0x100+31-k after 9 cycles.
REQ-029 SHALL cover: 20 back-to-back beats, out_ready low for cycles 12-15 -> all 20 beats delivered in order with no loss, and in_ready drops once the pipeline is full.
REQ-030 SHALL cover: ctrl_valid held high while 3 beats are in flight -> ctrl_ready = 0 until the last beat drains, the load occurs, and in_ready = 0 in that cycle.
REQ-031 SHALL cover: n_rst asserted with 5 beats in flight -> out_valid = 0 immediately, and no stale beats emerge after release.
REQ-032 SHALL cover, with XBAR_PERF_CNT_EN: beat_cnt preloaded via force to 0xFFFFFFFF, one beat delivered -> beat_cnt = 0.
